// File: rtl/ncl_pkg.sv
// Shared NCL dual-rail encoding constants, injector state enum and encoders.
package ncl_pkg;

    localparam logic [1:0] NCL_NULL    = 2'b00;
    localparam logic [1:0] NCL_D0      = 2'b01;
    localparam logic [1:0] NCL_D1      = 2'b10;
    localparam logic [1:0] NCL_ILLEGAL = 2'b11;

    localparam int NCL_MAXW = 32;

    typedef enum logic [2:0] {
        RST_WAIT,
        IDLE,
        DATA,
        NULLW,
        HOLD
    } inj_state_e;

    function automatic logic [1:0] ncl_enc_bit(input logic v);
        return v ? NCL_D1 : NCL_D0;
    endfunction

    function automatic logic [2*NCL_MAXW-1:0] ncl_encode(
        input logic [NCL_MAXW-1:0] v
    );
        logic [2*NCL_MAXW-1:0] r;
        r = '0;
        for (int i = 0; i < NCL_MAXW; i++) begin
            r[2*i +: 2] = ncl_enc_bit(v[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/ncl_ack_sync.sv
// Multi-flop synchroniser for an asynchronous completion acknowledge.
module ncl_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ack_i,
    output logic ack_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
        end
    end

    assign ack_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ncl_operand_injector.sv
// Clocked DATA/NULL injector into a dual-rail NCL ALU stage.
// Optional acknowledge timeout: define INJ_TIMEOUT_EN.
module ncl_operand_injector
    import ncl_pkg::*;
#(
    parameter int NBITS       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int NULL_HOLD   = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NBITS-1:0]   a_bin,
    input  logic [NBITS-1:0]   b_bin,
    input  logic               opr_bin,
    output logic [2*NBITS-1:0] a,
    output logic [2*NBITS-1:0] b,
    output logic [1:0]         opr,
    input  logic               ack_in,
    output logic               busy,
    output logic [7:0]         tx_count,
    output logic               err
);

    localparam int CMAX0 = (TIMEOUT_CYC > SYNC_STAGES) ? TIMEOUT_CYC : SYNC_STAGES;
    localparam int CMAX  = (CMAX0 > NULL_HOLD) ? CMAX0 : NULL_HOLD;
    localparam int CW    = ($clog2(CMAX + 1) > 8) ? $clog2(CMAX + 1) : 8;

    logic               ack_s;
    logic               to_hit;
    inj_state_e         state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*NBITS-1:0] a_q, b_q, a_d, b_d;
    logic [1:0]         opr_q, opr_d;
    logic               in_ready_q, busy_q;
    logic [7:0]         tx_q;

    ncl_ack_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rst  (rst),
        .ack_i(ack_in),
        .ack_o(ack_s)
    );

    always_comb begin
        a_d   = '0;
        b_d   = '0;
        opr_d = ncl_enc_bit(opr_bin);
        for (int i = 0; i < NBITS; i++) begin
            a_d[2*i +: 2] = ncl_enc_bit(a_bin[i]);
            b_d[2*i +: 2] = ncl_enc_bit(b_bin[i]);
        end
    end

`ifdef INJ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    logic err_q;

    assign to_hit = (state_q == DATA || state_q == NULLW)
                 && (cnt_q >= CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    localparam bit TO_EN = 1'b0;
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

    // cnt_q is shared: sync flush in RST_WAIT, timeout in DATA/NULLW, HOLD length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_WAIT;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            opr_q      <= NCL_NULL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_q       <= '0;
        end else begin
            unique case (state_q)
                RST_WAIT: begin
                    if (cnt_q < CW'(SYNC_STAGES)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else if (!ack_s) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= DATA;
                        a_q        <= a_d;
                        b_q        <= b_d;
                        opr_q      <= opr_d;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                    end
                end
                DATA, NULLW: begin
                    if (to_hit) begin
                        state_q <= RST_WAIT;
                        a_q     <= '0;
                        b_q     <= '0;
                        opr_q   <= NCL_NULL;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (state_q == DATA && ack_s) begin
                        state_q <= NULLW;
                        a_q     <= '0;
                        b_q     <= '0;
                        opr_q   <= NCL_NULL;
                        cnt_q   <= '0;
                    end else if (state_q == NULLW && !ack_s) begin
                        state_q <= HOLD;
                        busy_q  <= 1'b0;
                        tx_q    <= tx_q + 8'd1;
                        cnt_q   <= '0;
                    end else if (TO_EN) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q >= CW'(NULL_HOLD - 1)) begin
                        state_q    <= IDLE;
                        in_ready_q <= 1'b1;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= RST_WAIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign opr      = opr_q;
    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign tx_count = tx_q;

endmodule

// File: doc/ncl_operand_injector.md
Name: ncl_operand_injector

Overview:
- Clocked front-end that feeds the dual-rail NCL ALU stage directly upstream of it.
- Accepts single-rail operands A, B and the opcode bit over a valid/ready interface, then encodes them as dual-rail DATA wavefronts.
- Runs the 4-phase DATA/NULL handshake against the ALU stage's completion acknowledge, which is synchronised into the clock domain.
- Gives the clocked test/control domain a clean way to inject operations into the asynchronous pipeline.

Parameters:
- NBITS, 4, operand width in single-rail bits; the dual-rail outputs are 2*NBITS wide.
- SYNC_STAGES, 2, flip-flop stages on the incoming acknowledge (minimum 2).
- NULL_HOLD, 1, minimum clock cycles NULL is held before the next DATA may be issued (minimum 1).
- TIMEOUT_CYC, 255, cycles to wait for an acknowledge edge before flagging an error (only with INJ_TIMEOUT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  injector can accept an operand set this cycle
- a_bin  input  NBITS  single-rail operand A
- b_bin  input  NBITS  single-rail operand B
- opr_bin  input  1  single-rail opcode bit
- a  output  2*NBITS  dual-rail A to the ALU stage
- b  output  2*NBITS  dual-rail B to the ALU stage
- opr  output  2  dual-rail opcode to the ALU stage
- ack_in  input  1  ALU stage completion acknowledge; high means DATA has been latched and NULL is requested
- busy  output  1  a wavefront is in flight
- tx_count  output  8  completed DATA+NULL cycles, wraps 255 to 0
- err  output  1  sticky timeout flag; reads 0 when INJ_TIMEOUT_EN is off

Behaviour:
- Dual-rail encoding per bit i: pair {[2i+1], [2i]}.
  - NULL = 00, DATA0 = 01, DATA1 = 10.
  - 11 is illegal and must never be driven.
- All dual-rail outputs are registered and change only in the cycle of a state transition.
- The acknowledge is used only through the SYNC_STAGES synchroniser, giving ack_s.
- Reset values: a, b and opr all-NULL; in_ready=0; busy=0; tx_count=0; err=0; state RST_WAIT.
- State machine:
  - RST_WAIT: outputs NULL. Go to IDLE when ack_s=0. This covers a downstream stage still holding ack high after a mid-operation reset.
  - IDLE: in_ready=1. When in_valid=1, capture the operands and go to DATA. The encoded DATA appears on a/b/opr the next cycle, so latency is 1 cycle from acceptance.
  - DATA: busy=1, in_ready=0, outputs hold DATA. When ack_s=1, drive all-NULL and go to NULLW.
  - NULLW: outputs NULL. When ack_s=0, go to HOLD and increment tx_count.
  - HOLD: outputs NULL for NULL_HOLD cycles, then go to IDLE.
- in_ready is high only in IDLE. in_valid in any other state is ignored and nothing is captured.
- Back-to-back: if in_valid is held high, the next set is accepted in the first IDLE cycle. There is no idle bubble beyond HOLD.
- Outputs never move directly DATA to DATA or NULL to DATA without passing through the sequence above. Every wavefront is complete: all bits switch in the same cycle.
- An ack_s edge that arrives in a state not waiting for it is ignored.
- rst at any cycle forces the reset values on the next edge and aborts any wavefront in flight.

Optional Feature:
- Macro: INJ_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter runs in DATA and NULLW and clears on every state change.
  - Reaching TIMEOUT_CYC sets err=1. err is sticky until rst.
  - The FSM forces NULL, enters RST_WAIT, and does not increment tx_count for the aborted transfer.
- Not defined: no counter exists, err is tied to 0, and the FSM waits indefinitely.

Decomposition:
- Shared package ncl_pkg:
  - encoding constants NCL_NULL, NCL_D0, NCL_D1 and the illegal pattern;
  - state enum {RST_WAIT, IDLE, DATA, NULLW, HOLD};
  - a function encoding a single-rail vector into a dual-rail vector.
- One sub-module, ncl_ack_sync: a SYNC_STAGES flip-flop synchroniser with reset value 0. It is reused by the downstream result-collector stage.

Test Plan:
- Reset release, ack_in=0 → in_ready rises after SYNC_STAGES+1 cycles; a/b/opr stay all-zero.
- Accept a=4'h5, b=4'hA, opr=1 → next cycle a=8'b01100110, b=8'b10011001, opr=2'b10, busy=1. After ack_in=1, outputs return to NULL within SYNC_STAGES+1 cycles. After ack_in=0, tx_count=1.
- in_valid held high with 3 operand sets and an acknowledging ALU model → exactly 3 DATA wavefronts, each separated by at least NULL_HOLD NULL cycles, tx_count=3, no 11 pair ever observed.
- rst asserted during DATA while ack_in=1 → outputs NULL next cycle; in_ready stays 0 until ack_in drops, then rises.
- INJ_TIMEOUT_EN defined, TIMEOUT_CYC=16, ack_in stuck at 0 → after 16 cycles in DATA, err=1, outputs NULL, tx_count unchanged.
- tx_count preset via 255 completed transfers, then one more → tx_count wraps to 0.
